// File: rtl/add_operand_sequencer_if.sv
// add_operand_sequencer_if: operand strobe bus, adder drive/return and result signals
interface add_operand_sequencer_if #(parameter int N = 8);
    logic         load;
    logic [N-1:0] data_in;
    logic         sub;
    logic         ready;
    logic [N-1:0] adder_a;
    logic [N-1:0] adder_b;
    logic         adder_cin;
    logic [N-1:0] adder_sum;
    logic         adder_cout;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         result_valid;
    modport master (
        output load, data_in, sub, adder_sum, adder_cout,
        input  ready, adder_a, adder_b, adder_cin, result, carry, overflow, result_valid
    );
    modport slave (
        input  load, data_in, sub, adder_sum, adder_cout,
        output ready, adder_a, adder_b, adder_cin, result, carry, overflow, result_valid
    );
endinterface

// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer: collects A then B(+sub), drives an external adder, registers sum/carry/overflow
module add_operand_sequencer #(parameter int N = 8) (
    input logic                    clk,
    input logic                    reset,
    add_operand_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_A, S_B, S_ADD} state_t;
    state_t       r_state, w_next;
    logic [N-1:0] r_a, r_b, r_result, w_b;
    logic         r_sub, r_carry, r_overflow, r_valid, w_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= S_A;
        else       r_state <= w_next;
    always_comb
        w_next = (r_state == S_ADD)            ? S_A   :
                 (r_state == S_B && bus.load)  ? S_ADD :
                 (r_state == S_A && bus.load)  ? S_B   : r_state;
    always_comb
        w_ready = (r_state != S_ADD);
    // subtraction is A + ~B + 1, so the inversion and carry-in come from the stored sub
    assign w_b = r_sub ? ~r_b : r_b;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (r_state == S_A && bus.load) r_a <= bus.data_in;
            if (r_state == S_B && bus.load) begin
                r_b   <= bus.data_in;
                r_sub <= bus.sub;
            end
            if (r_state == S_ADD) begin
                r_result   <= bus.adder_sum;
                r_carry    <= bus.adder_cout;
                r_overflow <= (r_a[N-1] == w_b[N-1]) && (bus.adder_sum[N-1] != r_a[N-1]);
            end
            r_valid <= (r_state == S_ADD);
        end
    assign bus.ready        = w_ready;
    assign bus.adder_a      = r_a;
    assign bus.adder_b      = w_b;
    assign bus.adder_cin    = r_sub;
    assign bus.result       = r_result;
    assign bus.carry        = r_carry;
    assign bus.overflow     = r_overflow;
    assign bus.result_valid = r_valid;
endmodule

// File: tb/tb_add_operand_sequencer.sv
// tb_add_operand_sequencer: directed and random operations against an arithmetic reference model
module tb_add_operand_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    add_operand_sequencer_if #(.N(8)) bus();
    add_operand_sequencer #(.N(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    // the attached ripple-carry adder
    assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b} + {8'd0, bus.adder_cin};
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input int gap);
        int ua, ub, sa, sb, st;
        logic [7:0] exp_res, exp_effb;
        logic exp_c, exp_ov;
        ua = a; ub = b;
        sa = int'($signed(a)); sb = int'($signed(b));
        st = s ? sa - sb : sa + sb;
        exp_res  = 8'((s ? ua - ub : ua + ub) & 255);
        exp_c    = s ? (ua >= ub) : (ua + ub > 255);
        exp_ov   = (st > 127) || (st < -128);
        exp_effb = s ? ~b : b;
        bus.load = 1'b1; bus.data_in = a; bus.sub = ~s;
        tick();
        chk("a_capture", bus.adder_a, a);
        chk("ready_sb", bus.ready, 1);
        chk("valid_sb", bus.result_valid, 0);
        bus.load = 1'b0;
        repeat (gap) tick();
        chk("a_hold", bus.adder_a, a);
        bus.load = 1'b1; bus.data_in = b; bus.sub = s;
        tick();
        bus.data_in = ~a; bus.sub = ~s;
        chk("ready_add", bus.ready, 0);
        chk("adder_b", bus.adder_b, exp_effb);
        chk("adder_cin", bus.adder_cin, s);
        chk("valid_early", bus.result_valid, 0);
        tick();
        bus.load = 1'b0;
        chk("valid_pulse", bus.result_valid, 1);
        chk("result", bus.result, exp_res);
        chk("carry", bus.carry, exp_c);
        chk("overflow", bus.overflow, exp_ov);
        chk("ready_back", bus.ready, 1);
        chk("a_not_reloaded", bus.adder_a, a);
        tick();
        chk("valid_drop", bus.result_valid, 0);
        chk("result_hold", bus.result, exp_res);
    endtask
    initial begin
        reset = 1'b1;
        bus.load = 1'b0; bus.data_in = '0; bus.sub = 1'b0;
        #1;
        chk("rst_result", bus.result, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_adder_a", bus.adder_a, 0);
        tick();
        reset = 1'b0;
        tick();
        run_op(8'h7F, 8'h80, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b1, 2);
        run_op(8'h03, 8'h04, 1'b0, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        // load held high: A, B, ignored cycle, repeating
        bus.load = 1'b1; bus.data_in = 8'h10; bus.sub = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("hold_ready", bus.ready, (i % 3) != 2);
            chk("hold_valid", bus.result_valid, (i % 3) == 0);
            if (i % 3 == 0) chk("hold_result", bus.result, 8'h20);
        end
        bus.load = 1'b0;
        tick();
        chk("hold_valid_drop", bus.result_valid, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        // reset mid-operation with A loaded
        bus.load = 1'b1; bus.data_in = 8'h55;
        tick();
        bus.load = 1'b0;
        chk("pre_rst_a", bus.adder_a, 8'h55);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", bus.result, 0);
        chk("arst_carry", bus.carry, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_valid", bus.result_valid, 0);
        chk("arst_ready", bus.ready, 1);
        chk("arst_adder_a", bus.adder_a, 0);
        chk("arst_adder_b", bus.adder_b, 0);
        chk("arst_cin", bus.adder_cin, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_valid", bus.result_valid, 0);
        run_op(8'h12, 8'h34, 1'b0, 0);
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add_operand_sequencer.md
Name: add_operand_sequencer

Overview:
- Upstream feeder and result capture stage for the combinational n-bit ripple-carry adder (full_add_n_bit).
- Collects operand A, then operand B (with an add/subtract select) from one shared data bus over a strobe handshake.
- Drives the adder's a/b/c_in from registers, then registers the adder's sum and carry-out. Signed overflow is computed alongside.
- Sits between the board switch/key debouncers and the HEX display driver.

Parameters:
- N, 8, operand/result width; must match the N of the attached full_add_n_bit.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- load  input  1  one-cycle strobe; data_in is valid when high.
- data_in  input  N  operand value presented with load.
- sub  input  1  sampled together with operand B; 1 = compute A-B, 0 = A+B.
- ready  output  1  high when a load will be accepted.
- adder_a  output  N  to adder .a.
- adder_b  output  N  to adder .b.
- adder_cin  output  1  to adder .c_in.
- adder_sum  input  N  from adder .sum.
- adder_cout  input  1  from adder .c_out.
- result  output  N  registered sum.
- carry  output  1  registered carry-out (for subtract, 1 = no borrow).
- overflow  output  1  registered two's-complement overflow.
- result_valid  output  1  one-cycle pulse when result/carry/overflow update.

Behaviour:
- Clock, reset: one clock (clk); reset is asynchronous and active-high.
- Reset: state=S_A, A_reg=0, B_reg=0, sub_reg=0, result=0, carry=0, overflow=0, result_valid=0, ready=1.
  - Reset mid-operation aborts any pending add; the result is lost and no result_valid is issued.
- State S_A (ready=1): load=1 -> A_reg<=data_in, go to S_B. load=0 -> stay.
- State S_B (ready=1): load=1 -> B_reg<=data_in, sub_reg<=sub, go to S_ADD. load=0 -> stay; A_reg is held indefinitely.
- State S_ADD (ready=0):
  - Unconditionally capture result<=adder_sum and carry<=adder_cout.
  - overflow<=(adder_a[N-1]==adder_b[N-1]) && (adder_sum[N-1]!=adder_a[N-1]).
  - result_valid<=1 for exactly one cycle; go to S_A.
  - A load during S_ADD is ignored; it is not queued and does not alter A_reg.
- Adder drive (combinational from registers, valid in every state):
  - adder_a=A_reg.
  - adder_b = sub_reg ? ~B_reg : B_reg.
  - adder_cin=sub_reg.
- Latency: B accepted at edge k -> S_ADD during cycle k..k+1 -> result, carry, overflow registered and result_valid=1 after edge k+1. result_valid returns to 0 after edge k+2.
- Back-to-back: a load in the cycle after S_ADD is accepted as the next A. Minimum issue interval is 3 cycles per result.
- result/carry/overflow hold their last value until the next S_ADD capture.
- Width rules:
  - All arithmetic is modulo 2^N; carry is the N-th bit.
  - Overflow uses signed interpretation of adder_a/adder_b, i.e. of the effective operands after inversion.
- load held high continuously: accepted once per state visit (A, B, then 1 ignored cycle in S_ADD), repeating. The same data_in is loaded as both operands if unchanged.
- sub is ignored except in the S_B accept cycle.

Test Plan:
- Assert reset mid-S_B after loading A=0x55 -> all outputs 0, ready=1, state S_A. The next two loads start a fresh operation and no stray result_valid is seen.
- Load A=0x7F, B=0x80, sub=0 -> result=0xFF, carry=0, overflow=0, result_valid high exactly one cycle, 2 cycles after B load.
- A=0x7F, B=0x01, sub=0 -> result=0x80, carry=0, overflow=1. Then A=0xFF, B=0x01 -> result=0x00, carry=1, overflow=0.
- A=0x05, B=0x07, sub=1 -> adder_b=0xF8, adder_cin=1, result=0xFE, carry=0, overflow=0. A=0x80, B=0x01, sub=1 -> result=0x7F, carry=1, overflow=1.
- Hold load=1 with data_in=0x10 for 6 cycles -> two results of 0x20, each with a one-cycle result_valid pulse. The load during S_ADD is ignored (ready=0 that cycle).
- Toggle sub during S_A and S_ADD cycles but hold it at 0 on the B accept -> addition is performed (A=0x03, B=0x04 -> 0x07).
